// File: rtl/and3_seq_pkg.sv
// Shared types and default widths for the AND3 operand sequencer.
package and3_seq_pkg;

   // Load a, load b, load c, let the AND stage settle, present the result
   typedef enum logic [2:0] {
      S_A,
      S_B,
      S_C,
      S_EVAL,
      S_OUT
   } seq_state_t;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/and_gate_3bit.sv
// Combinational 3-input bitwise AND stage fed by the operand sequencer.
module and_gate_3bit (
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic [2:0] c,
   output logic [2:0] y
);

   assign y = a & b & c;

endmodule

// File: rtl/and3_operand_sequencer.sv
// Handshaked feeder for the AND stage: gathers three operands from a
// valid/ready stream, waits one cycle for the AND stage, and returns its
// result on a valid/ready output stream.
module and3_operand_sequencer
   import and3_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] c_o,
   input  logic [WIDTH-1:0] y_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] res_cnt
);

   seq_state_t state;

   // Operands are accepted only in the three load states
   always_comb begin
      in_ready = (state == S_A) || (state == S_B) || (state == S_C);
   end

   // Sequencer: operand capture, result capture, output handshake and count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_A;
         a_o       <= '0;
         b_o       <= '0;
         c_o       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         res_cnt   <= '0;
      end else if (flush) begin
         // Abort: drop partial triple and pending result, keep operands
         state     <= S_A;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_A: if (in_valid) begin
               a_o   <= in_data;
               state <= S_B;
            end
            S_B: if (in_valid) begin
               b_o   <= in_data;
               state <= S_C;
            end
            S_C: if (in_valid) begin
               c_o   <= in_data;
               state <= S_EVAL;
            end
            S_EVAL: begin
               out_data  <= y_i;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: if (out_ready) begin
               out_valid <= 1'b0;
               res_cnt   <= res_cnt + CNT_W'(1);
               state     <= S_A;
            end
            default: begin
               state     <= S_A;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_and3_operand_sequencer.sv
// Directed bench for and3_operand_sequencer wired to and_gate_3bit.
module tb_and3_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_data;
   logic [2:0] a_o, b_o, c_o, y;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_data;
   logic [7:0] res_cnt;

   int vectors = 0;
   int miscompares = 0;
   int exp_cnt = 0;

   and3_operand_sequencer #(.WIDTH(3), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .a_o(a_o), .b_o(b_o), .c_o(c_o), .y_i(y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .res_cnt(res_cnt)
   );

   and_gate_3bit u_and (.a(a_o), .b(b_o), .c(c_o), .y(y));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Caller sits 1 time unit after a rising edge; returns likewise.
   task automatic push(input logic [2:0] w);
      for (int i = 0; i < 8 && in_ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      chk("push_in_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic triple(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic [2:0] exp, input string tag);
      push(a);
      push(b);
      push(c);
      for (int i = 0; i < 4 && out_valid !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_data"}, 32'(out_data), 32'(exp));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      chk({tag, "_cnt"}, 32'(res_cnt), exp_cnt);
   endtask

   initial begin
      logic [2:0] ra, rb, rc;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_res_cnt", 32'(res_cnt), 0);
      chk("rst_a_o", 32'(a_o), 0);
      chk("rst_out_data", 32'(out_data), 0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic with out_ready held high: result one edge after c accepted
      out_ready = 1'b1;
      push(3'b101); push(3'b110); push(3'b111);
      chk("basic_eval_valid", 32'(out_valid), 0);
      chk("basic_eval_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("basic_out_valid", 32'(out_valid), 1);
      chk("basic_out_data", 32'(out_data), 'h4);
      chk("basic_cnt_before", 32'(res_cnt), 0);
      @(posedge clk); #1;
      chk("basic_done_valid", 32'(out_valid), 0);
      chk("basic_res_cnt", 32'(res_cnt), 1);
      chk("basic_in_ready", 32'(in_ready), 1);
      out_ready = 1'b0;
      exp_cnt = 1;

      triple(3'b111, 3'b111, 3'b111, 3'b111, "ones");
      triple(3'b000, 3'b000, 3'b000, 3'b000, "zeros");
      chk("ones_zeros_cnt", 32'(res_cnt), 3);
      triple(3'b111, 3'b000, 3'b111, 3'b000, "mixed");

      // Backpressure: result held while out_ready low
      push(3'b001); push(3'b011); push(3'b101);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 'h1);
         chk("bp_in_ready", 32'(in_ready), 0);
         @(posedge clk); #1;
      end
      chk("bp_cnt_held", 32'(res_cnt), exp_cnt);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_cnt++;
      chk("bp_release_valid", 32'(out_valid), 0);
      chk("bp_release_in_ready", 32'(in_ready), 1);
      chk("bp_release_cnt", 32'(res_cnt), exp_cnt);

      // Flush mid-load: partial triple discarded, operands kept
      push(3'b111); push(3'b111);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_a_kept", 32'(a_o), 'h7);
      chk("flush_b_kept", 32'(b_o), 'h7);
      triple(3'b111, 3'b111, 3'b000, 3'b000, "flush_load");

      // Flush coinciding with a valid word in S_B: word must not land in b
      push(3'b101);
      flush = 1'b1; in_valid = 1'b1; in_data = 3'b010;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flushw_a", 32'(a_o), 'h5);
      chk("flushw_b_not_captured", 32'(b_o), 'h7);
      triple(3'b011, 3'b110, 3'b111, 3'b010, "flush_word");

      // Flush in S_OUT with out_ready high: result dropped, no count
      push(3'b111); push(3'b111); push(3'b111);
      @(posedge clk); #1;
      chk("flusho_valid_pre", 32'(out_valid), 1);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b0;
      chk("flusho_valid", 32'(out_valid), 0);
      chk("flusho_cnt", 32'(res_cnt), exp_cnt);
      chk("flusho_in_ready", 32'(in_ready), 1);

      // Async reset while in S_OUT
      push(3'b110); push(3'b011); push(3'b111);
      @(posedge clk); #1;
      chk("areset_pre_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_valid", 32'(out_valid), 0);
      chk("areset_cnt", 32'(res_cnt), 0);
      chk("areset_data", 32'(out_data), 0);
      chk("areset_a", 32'(a_o), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cnt = 0;
      triple(3'b101, 3'b110, 3'b111, 3'b100, "post_reset");

      // 256 back-to-back triples: counter wraps back to its starting value
      for (int n = 0; n < 256; n++) begin
         ra = 3'($urandom_range(0, 7));
         rb = 3'($urandom_range(0, 7));
         rc = 3'($urandom_range(0, 7));
         triple(ra, rb, rc, ra & rb & rc, "wrap");
      end
      chk("wrap_final_cnt", 32'(res_cnt), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
